// File: rtl/load_store_unit.sv
// load_store_unit: req/ack data-memory access stage with lane steering, load extension and ack timeout
module load_store_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CMAX = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3;
    logic [1:0]    off;
    logic          any_req, legal, aligned, valid;
    logic [3:0]    be_n;
    logic [31:0]   wd_n, sh, ld_val;
    logic [15:0]   hf;

    // request decode, store lane steering and load extraction from the captured access
    always_comb begin
        any_req = mem_rd | mem_wr;
        legal   = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) ||
                  (mem_rd && (funct3 == 3'b100 || funct3 == 3'b101));
        aligned = funct3[1] ? (addr[1:0] == 2'b00) : funct3[0] ? !addr[0] : 1'b1;
        valid   = (mem_rd ^ mem_wr) && legal && aligned;
        be_n    = funct3[1] ? 4'b1111 : funct3[0] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        wd_n    = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        sh      = bus_rdata >> {off, 3'b000};
        hf      = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_val  = f3[1] ? bus_rdata :
                  f3[0] ? {{16{~f3[2] & hf[15]}}, hf} : {{24{~f3[2] & sh[7]}}, sh[7:0]};
        stall   = !reset && (state == REQ || (state == IDLE && valid));
    end

    // access FSM: capture in IDLE, hold the bus in REQ until ack or timeout, pulse done in RESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            f3        <= '0;
            off       <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        state     <= REQ;
                        cnt       <= '0;
                        f3        <= funct3;
                        off       <= addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= mem_wr;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_n;
                        bus_wdata <= wd_n;
                    end else if (any_req) begin
                        fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state   <= RESP;
                        cnt     <= '0;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        if (!bus_we) rdata <= ld_val;
                    end else if (cnt == CMAX) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        bus_req <= 1'b0;
                        fault   <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a spec-level model
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clock, reset, mem_rd, mem_wr, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata, rdata, bus_addr, bus_wdata;
    logic        stall, done, fault, bus_req, bus_we;
    logic [3:0]  bus_be;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rdata = 0;

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // access size in bytes, 0 when the funct3 is not legal for this direction
    function automatic int size_of(input logic rd, input logic [2:0] f);
        case (f)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return rd ? 1 : 0;
            3'd5: return rd ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f, input int o, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * o)) & 32'hFF;
        h = (r >> (16 * (o / 2))) & 32'hFFFF;
        case (f)
            3'd0: return b >= 128 ? b - 256 : b;
            3'd1: return h >= 32768 ? h - 65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return r;
        endcase
    endfunction

    // one access: request held while stalled, ack after k REQ cycles, dropped after done
    task automatic access(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rv, input int k);
        int sz, o, stalls;
        logic v;
        logic [31:0] ebe, ewd;
        sz = size_of(rd, f);
        o = a % 4;
        v = (rd ^ wr) && sz != 0 && (a % sz) == 0;
        ebe = sz == 4 ? 32'hF : sz == 2 ? 32'h3 << o : 32'h1 << o;
        ewd = sz == 4 ? d : sz == 2 ? (d & 32'hFFFF) * 32'h00010001 : (d & 32'hFF) * 32'h01010101;
        @(negedge clock);
        mem_rd = rd; mem_wr = wr; funct3 = f; addr = a; wdata = d;
        #1;
        chk("stall_accept", stall, v);
        stalls = stall ? 1 : 0;
        if (!v) begin
            @(negedge clock);
            mem_rd = 0; mem_wr = 0;
            #1;
            chk("bad_fault", fault, 1);
            chk("bad_no_req", bus_req, 0);
            chk("bad_stall", stall, 0);
            chk("bad_rdata", rdata, exp_rdata);
            @(negedge clock);
            chk("bad_fault_pulse", fault, 0);
        end else begin
            for (int i = 1; i <= k; i++) begin
                @(negedge clock);
                chk("req_high", bus_req, 1);
                chk("req_we", bus_we, wr);
                chk("req_addr", bus_addr, a & ~32'h3);
                chk("req_be", bus_be, ebe);
                if (wr) chk("req_wdata", bus_wdata, ewd);
                stalls += stall ? 1 : 0;
                if (i == k) begin bus_ack = 1; bus_rdata = rv; end
            end
            @(negedge clock);
            bus_ack = 0; bus_rdata = $urandom;
            if (rd) exp_rdata = ld_model(f, o, rv);
            chk("resp_done", done, 1);
            chk("resp_stall", stall, 0);
            chk("resp_req", bus_req, 0);
            chk("resp_fault", fault, 0);
            chk("resp_rdata", rdata, exp_rdata);
            chk("stall_cycles", stalls, k + 1);
            mem_rd = 0; mem_wr = 0;
            @(negedge clock);
            chk("after_done", done, 0);
            chk("no_reissue", bus_req, 0);
        end
    endtask

    initial begin
        int n;
        logic rd, wr;
        logic [2:0] f;
        logic [31:0] a;
        reset = 1; mem_rd = 0; mem_wr = 0; funct3 = 0; addr = 0; wdata = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(negedge clock);
        chk("rst_req", bus_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", bus_be, 0);
        reset = 0;
        @(negedge clock);
        chk("idle_stall", stall, 0);

        access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3);
        chk("lw_value", rdata, 32'hDEADBEEF);
        access(1, 0, 3'b000, 32'h203, 0, 32'h80FFFF7F, 1);
        chk("lb_value", rdata, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h203, 0, 32'h80FFFF7F, 2);
        chk("lbu_value", rdata, 32'h00000080);
        access(0, 1, 3'b000, 32'h402, 32'h000000A5, 0, 1);
        access(0, 1, 3'b001, 32'h402, 32'h00001234, 0, 2);
        access(1, 0, 3'b010, 32'h102, 0, 0, 1);
        access(1, 0, 3'b001, 32'h101, 0, 0, 1);
        access(1, 1, 3'b010, 32'h100, 0, 0, 1);
        access(0, 1, 3'b100, 32'h100, 0, 0, 1);
        access(1, 0, 3'b101, 32'h302, 0, 32'h8001_1234, TO);

        // no ack: bus_req must stay up exactly TO cycles, then fault and cleared rdata
        @(negedge clock);
        mem_rd = 1; funct3 = 3'b010; addr = 32'h300;
        n = 0;
        @(negedge clock);
        while (bus_req && n < 4 * TO) begin
            n++;
            @(negedge clock);
        end
        mem_rd = 0;
        #1;
        exp_rdata = 0;
        chk("to_req_cycles", n, TO);
        chk("to_fault", fault, 1);
        chk("to_rdata", rdata, 0);
        chk("to_stall", stall, 0);
        @(negedge clock);
        chk("to_fault_pulse", fault, 0);
        chk("to_idle_req", bus_req, 0);

        access(1, 0, 3'b010, 32'h104, 0, 32'h1234_5678, 2);

        // reset two cycles into REQ
        @(negedge clock);
        mem_rd = 1; funct3 = 3'b010; addr = 32'h500;
        repeat (2) @(negedge clock);
        chk("mid_req_up", bus_req, 1);
        reset = 1;
        #1;
        chk("mid_rst_req", bus_req, 0);
        chk("mid_rst_stall", stall, 0);
        mem_rd = 0;
        @(negedge clock);
        reset = 0;
        exp_rdata = 0;
        chk("mid_rst_rdata", rdata, 0);
        @(negedge clock);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fault", fault, 0);
        access(1, 0, 3'b010, 32'h500, 0, 32'hCAFE_F00D, 1);

        for (int t = 0; t < 60; t++) begin
            rd = 1'($urandom % 2);
            wr = rd ? ($urandom % 8 == 0) : 1'b1;
            f = 3'($urandom % 8);
            a = $urandom;
            if ($urandom % 4 != 0) a = a & (f[1] ? ~32'h3 : f[0] ? ~32'h1 : ~32'h0);
            access(rd, wr, f, a, $urandom, $urandom, 1 + int'($urandom % TO));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
